regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Sequences the single register-file write port between the LDR writeback path (ldr_* inputs,
//  fed by w_en_ldr) and the ALU/execute writeback path (alu_* inputs).
//  Writes that cannot take the port this cycle are queued in an in-order pending FIFO.
//  Operand reads hit in the FIFO through two forwarding lookups.
//  A registered sel_stall holds the front end off before the FIFO can overflow.
// PARAMETERS
//  DEPTH  4   pending-write FIFO entries; legal range >= 3
//  AW     4   register address width (R0..R15)
//  DW     32  data width
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  ldr_wr_valid in   1      LDR writeback request (w_en_ldr)
//  ldr_wr_addr  in   AW     LDR destination register
//  ldr_wr_data  in   DW     loaded data
//  alu_wr_valid in   1      ALU writeback request
//  alu_wr_addr  in   AW     ALU destination register
//  alu_wr_data  in   DW     ALU result
//  fwd_addr_a   in   AW     forwarding lookup address, read port A
//  fwd_addr_b   in   AW     forwarding lookup address, read port B
//  w_en         out  1      register-file write enable (registered)
//  w_addr       out  AW     register-file write address (registered)
//  w_data       out  DW     register-file write data (registered)
//  fwd_hit_a    out  1      pending FIFO holds a write to fwd_addr_a (combinational)
//  fwd_data_a   out  DW     youngest pending data for fwd_addr_a; 0 when no hit
//  fwd_hit_b    out  1      as fwd_hit_a, for port B
//  fwd_data_b   out  DW     as fwd_data_a, for port B
//  sel_stall    out  1      front-end stall request (registered)
//  pending_cnt  out  $clog2(DEPTH+1)  current FIFO occupancy
//  overflow_err out  1      sticky: a push was attempted while the FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM in EMPTY. Reset asserted mid-operation discards queued writes.
//  Arrival order is program order. Within a cycle, LDR is older than ALU.
//  Per-cycle port selection, in priority order:
//   1. FIFO non-empty: port takes FIFO head (pop). Valid LDR is pushed, then valid ALU is pushed.
//   2. FIFO empty, LDR valid: port takes LDR. Valid ALU is pushed.
//   3. FIFO empty, ALU valid only: port takes ALU directly.
//   4. Nothing valid: w_en=0. w_addr/w_data hold their previous values.
//  Latency: the write appears on w_* one cycle after it is selected, so an unqueued write takes 1 cycle.
//  Same-cycle pop and push are legal. Net occupancy change is within -1..+1.
//  FIFO pointers wrap modulo DEPTH. Full = count==DEPTH.
//  Any push while full is dropped and sets overflow_err. Only reset clears overflow_err.
//  Forwarding: scan all valid FIFO entries. Select the youngest entry whose address matches.
//  Same-address entries are written in FIFO order (WAW preserved).
//   Writes in flight on w_* are not forwarded; the regfile bypass covers them.
//  FSM, state updated from count_next:
//   EMPTY: count_next==0.
//   PEND: 0<count_next<DEPTH-1.
//   STALL: count_next>=DEPTH-1; sel_stall=1.
//  Transitions: EMPTY<->PEND on push/drain. PEND->STALL when count_next>=DEPTH-1.
//   STALL->PEND when count_next<=DEPTH-3; STALL->EMPTY when count_next==0. Otherwise stay in STALL (hysteresis).
//  sel_stall is registered. Upstream sends no writes in any cycle where sel_stall=1.
//   This bounds occupancy at DEPTH-1, so overflow_err stays 0 in legal operation.
//  Writes to R15 are arbitrated like any other register. No PC special-casing is done here.
// TESTING
//  T1 single ALU write: alu r3=0x11, FIFO empty -> next cycle w_en=1, w_addr=3, w_data=0x11; cnt=0.
//  T2 collision: ldr r1=0xA and alu r2=0xB in the same cycle -> w_* r1=0xA at +1, r2=0xB at +2;
//     fwd_addr_a=2 hits 0xB during +1 only.
//  T3 WAW: collisions queue alu r4=1 then r4=2 -> fwd_data for r4=2.
//     Port writes 1 before 2. Final regfile r4=2.
//  T4 stall: collisions on 3 consecutive cycles (DEPTH=4) -> sel_stall=1 when cnt reaches 3.
//     Drains one per cycle. Clears when cnt<=1. overflow_err=0.
//  T5 reset mid-drain: cnt=2, rst_n pulsed low -> immediately w_en=0, sel_stall=0, cnt=0, fwd_hit=0.
//  T6 overflow: force pushes with sel_stall ignored until full -> extra push dropped;
//     overflow_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: LDR vs ALU writeback, in-order pending FIFO,
// two-port forwarding from queued writes and a hysteretic front-end stall.
module regfile_write_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ldr_wr_valid,
    input  logic [AW-1:0]                ldr_wr_addr,
    input  logic [DW-1:0]                ldr_wr_data,
    input  logic                         alu_wr_valid,
    input  logic [AW-1:0]                alu_wr_addr,
    input  logic [DW-1:0]                alu_wr_data,
    input  logic [AW-1:0]                fwd_addr_a,
    input  logic [AW-1:0]                fwd_addr_b,
    output logic                         w_en,
    output logic [AW-1:0]                w_addr,
    output logic [DW-1:0]                w_data,
    output logic                         fwd_hit_a,
    output logic [DW-1:0]                fwd_data_a,
    output logic                         fwd_hit_b,
    output logic [DW-1:0]                fwd_data_b,
    output logic                         sel_stall,
    output logic [$clog2(DEPTH+1)-1:0]   pending_cnt,
    output logic                         overflow_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {ST_EMPTY, ST_PEND, ST_STALL} state_t;

    // Pointer add modulo DEPTH; n never exceeds DEPTH-1 so one correction suffices.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [PW:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + n;
        if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
        return s[PW-1:0];
    endfunction

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    state_t        state;

    logic          pop_c, full_c, push_ldr_c, push_alu_c, drop_c;
    logic [CW-1:0] count_next_c;
    logic [PW-1:0] tail_alu_c, tail_next_c;
    logic          sel_valid_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_data_c;
    state_t        state_next_c;

    assign pending_cnt = count;

    // Port selection, FIFO push/pop decisions and next occupancy.
    always_comb begin
        pop_c        = (count != '0);
        full_c       = (count == CW'(DEPTH));
        push_ldr_c   = ldr_wr_valid && pop_c && !full_c;
        push_alu_c   = alu_wr_valid && (pop_c || ldr_wr_valid) && !full_c;
        drop_c       = full_c && (ldr_wr_valid || alu_wr_valid);
        count_next_c = count - CW'(pop_c) + CW'(push_ldr_c) + CW'(push_alu_c);
        tail_alu_c   = push_ldr_c ? wrap_add(tail, (PW+1)'(1)) : tail;
        tail_next_c  = wrap_add(tail, (PW+1)'(push_ldr_c) + (PW+1)'(push_alu_c));
        sel_valid_c  = 1'b0;
        sel_addr_c   = '0;
        sel_data_c   = '0;
        if (pop_c) begin
            sel_valid_c = 1'b1;
            sel_addr_c  = fifo_addr[head];
            sel_data_c  = fifo_data[head];
        end else if (ldr_wr_valid) begin
            sel_valid_c = 1'b1;
            sel_addr_c  = ldr_wr_addr;
            sel_data_c  = ldr_wr_data;
        end else if (alu_wr_valid) begin
            sel_valid_c = 1'b1;
            sel_addr_c  = alu_wr_addr;
            sel_data_c  = alu_wr_data;
        end
    end

    // Occupancy FSM with hysteresis on leaving STALL.
    always_comb begin
        state_next_c = state;
        if (count_next_c == '0) begin
            state_next_c = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY, ST_PEND:
                    state_next_c = (count_next_c >= CW'(DEPTH - 1)) ? ST_STALL : ST_PEND;
                ST_STALL:
                    if (count_next_c <= CW'(DEPTH - 3)) state_next_c = ST_PEND;
                default:
                    state_next_c = ST_EMPTY;
            endcase
        end
    end

    // Forwarding: walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = wrap_add(head, (PW+1)'(k));
            if (CW'(k) < count) begin
                if (fifo_addr[idx] == fwd_addr_a) begin
                    fwd_hit_a  = 1'b1;
                    fwd_data_a = fifo_data[idx];
                end
                if (fifo_addr[idx] == fwd_addr_b) begin
                    fwd_hit_b  = 1'b1;
                    fwd_data_b = fifo_data[idx];
                end
            end
        end
    end

    // FIFO storage; entries are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (push_ldr_c) begin
            fifo_addr[tail] <= ldr_wr_addr;
            fifo_data[tail] <= ldr_wr_data;
        end
        if (push_alu_c) begin
            fifo_addr[tail_alu_c] <= alu_wr_addr;
            fifo_data[tail_alu_c] <= alu_wr_data;
        end
    end

    // Control state, write port and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            sel_stall    <= 1'b0;
            count        <= '0;
            head         <= '0;
            tail         <= '0;
            w_en         <= 1'b0;
            w_addr       <= '0;
            w_data       <= '0;
            overflow_err <= 1'b0;
        end else begin
            state     <= state_next_c;
            sel_stall <= (state_next_c == ST_STALL);
            count     <= count_next_c;
            tail      <= tail_next_c;
            if (pop_c) head <= wrap_add(head, (PW+1)'(1));
            w_en <= sel_valid_c;
            if (sel_valid_c) begin
                w_addr <= sel_addr_c;
                w_data <= sel_data_c;
            end
            if (drop_c) overflow_err <= 1'b1;
        end
    end

endmodule
